// File: rtl/gpr_snap_pkg.sv
// Shared types and default sizes for the GPR snapshot sequencer and its helpers.
// Widths match the 31 tapped integer registers (x1..x31) of an RV32 core.
package gpr_snap_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NUM_REGS = 31;
    localparam int DEF_IDX_W    = 5;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } snap_state_t;

    // One output beat as seen by the trace/compare consumer
    typedef struct packed {
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_XLEN-1:0]  data;
        logic                 last;
    } snap_beat_t;

endpackage

// File: rtl/gpr_snap_lsb_find.sv
// Lowest-set-bit encoder: reports whether any bit is set, the position of the lowest one,
// and whether any other set bit lies above it (i.e. the selected entry is not the last).
module gpr_snap_lsb_find #(
    parameter int WIDTH = 31,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic             above
);

    logic [WIDTH-1:0] onehot;

    // Two's-complement trick isolates the lowest set bit; everything else left is "above" it
    always_comb begin
        onehot = vec & (~vec + WIDTH'(1));
        found  = |vec;
        above  = |(vec & ~onehot);
        index  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gpr_snapshot_sequencer.sv
// Captures x1..x31 in one cycle and streams them as (index, data) beats over valid/ready,
// either all registers (full) or only those changed since the last completed snapshot (delta).
module gpr_snapshot_sequencer
    import gpr_snap_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REGS*XLEN-1:0] gpr_flat,
    input  logic                     snap_req,
    input  logic                     snap_delta,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic [XLEN-1:0]          out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         drop_cnt
);

    snap_state_t state, state_nxt;

    logic [XLEN-1:0]     snap_buf [NUM_REGS];
    logic [XLEN-1:0]     baseline [NUM_REGS];
    logic                base_vld;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_new;

    logic                ptr_found;
    logic                ptr_above;
    logic [IDX_W-1:0]    ptr;

    logic                stream_active;
    logic                capture;
    logic                handshake;
    logic                final_beat;
    logic                done_q;
    logic [CNT_W-1:0]    drop_q;

    gpr_snap_lsb_find #(
        .WIDTH (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_lsb_find (
        .vec   (pending),
        .found (ptr_found),
        .index (ptr),
        .above (ptr_above)
    );

    // flush outranks both a new capture and a same-cycle handshake
    assign stream_active = (state == STREAM) && ptr_found;
    assign capture       = (state == IDLE) && snap_req && !flush;
    assign handshake     = stream_active && out_ready && !flush;
    assign final_beat    = handshake && !ptr_above;

    // Entries to emit: everything when full mode or no baseline exists yet, else only changes
    always_comb begin
        pend_new = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_new[i] = !snap_delta || !base_vld ||
                          (gpr_flat[i*XLEN +: XLEN] != baseline[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture && (pend_new != '0)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (flush || final_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture buffer carries data only; pending gates its use, so no reset is needed
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_buf[i] <= gpr_flat[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending  <= '0;
            base_vld <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                baseline[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (capture) begin
                pending <= pend_new;
                if (pend_new == '0) begin
                    done_q <= 1'b1;
                end
            end
            if (state == STREAM) begin
                if (snap_req && (drop_q != '1)) begin
                    drop_q <= drop_q + CNT_W'(1);
                end
                if (flush) begin
                    pending <= '0;
                end else if (handshake) begin
                    pending[ptr] <= 1'b0;
                end
            end
            // Baseline only advances once a snapshot has been fully delivered
            if (final_beat) begin
                base_vld <= 1'b1;
                done_q   <= 1'b1;
                for (int i = 0; i < NUM_REGS; i++) begin
                    baseline[i] <= snap_buf[i];
                end
            end
        end
    end

    assign out_valid = stream_active;
    assign out_idx   = ptr + IDX_W'(1);
    assign out_data  = snap_buf[ptr];
    assign out_last  = stream_active && !ptr_above;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_gpr_snapshot_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor checks every presented beat.
module tb_gpr_snapshot_sequencer;
    import gpr_snap_pkg::*;

    localparam int XLEN     = DEF_XLEN;
    localparam int NUM_REGS = DEF_NUM_REGS;
    localparam int IDX_W    = DEF_IDX_W;
    localparam int CNT_W    = DEF_CNT_W;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_REGS*XLEN-1:0] gpr_flat;
    logic                     snap_req;
    logic                     snap_delta;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_idx;
    logic [XLEN-1:0]          out_data;
    logic                     out_last;
    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         drop_cnt;

    logic [XLEN-1:0] regs   [NUM_REGS];
    logic [XLEN-1:0] cap    [NUM_REGS];
    logic [XLEN-1:0] m_base [NUM_REGS];
    logic            m_base_vld;

    snap_beat_t exp_q[$];
    int total     = 0;
    int bad       = 0;
    int done_seen = 0;
    int done_exp  = 0;
    bit rand_en   = 1'b0;

    gpr_snapshot_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .gpr_flat   (gpr_flat),
        .snap_req   (snap_req),
        .snap_delta (snap_delta),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .drop_cnt   (drop_cnt)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            gpr_flat[i*XLEN +: XLEN] = regs[i];
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: any presented beat must match the head of the queue; it pops only on handshake
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_beat", 64'(out_valid), 64'd0);
                end else begin
                    check_output("beat_idx",  64'(out_idx),  64'(exp_q[0].idx));
                    check_output("beat_data", 64'(out_data), 64'(exp_q[0].data));
                    check_output("beat_last", 64'(out_last), 64'(exp_q[0].last));
                    if (out_ready && !flush) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                done_seen++;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (rand_en) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Builds the expected beat list from the model, then pulses snap_req for one cycle
    task automatic apply_stimulus(input logic delta);
        snap_beat_t b;
        logic       full_mode;
        int         n;
        n         = 0;
        full_mode = !delta || !m_base_vld;
        for (int i = 0; i < NUM_REGS; i++) begin
            cap[i] = regs[i];
            if (full_mode || (regs[i] != m_base[i])) begin
                b.idx  = IDX_W'(i + 1);
                b.data = regs[i];
                b.last = 1'b0;
                exp_q.push_back(b);
                n++;
            end
        end
        if (n > 0) begin
            b = exp_q.pop_back();
            b.last = 1'b1;
            exp_q.push_back(b);
        end
        snap_delta = delta;
        snap_req   = 1'b1;
        @(posedge clock);
        #1;
        snap_req   = 1'b0;
        snap_delta = 1'b0;
    endtask

    task automatic finish_snap(input int budget);
        int k;
        k = 0;
        done_exp++;
        while ((done_seen < done_exp) && (k < budget)) begin
            @(posedge clock);
            #1;
            k++;
        end
        check_output("done_count", 64'(done_seen), 64'(done_exp));
        check_output("queue_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            m_base[i] = cap[i];
        end
        m_base_vld = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_base[i] = '0;
        end
        m_base_vld = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        snap_req   = 1'b0;
        snap_delta = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = XLEN'((i + 1) * 'h11);
        end
        do_reset();
        check_output("rst_valid", 64'(out_valid), 64'd0);
        check_output("rst_last",  64'(out_last),  64'd0);
        check_output("rst_busy",  64'(busy),      64'd0);
        check_output("rst_done",  64'(done),      64'd0);
        check_output("rst_drop",  64'(drop_cnt),  64'd0);

        // Test 1: full snapshot, no backpressure, exact done timing
        $display("[TB] test 1: full snapshot");
        apply_stimulus(1'b0);
        check_output("t1_busy", 64'(busy), 64'd1);
        check_output("t1_first_valid", 64'(out_valid), 64'd1);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clock);
            #1;
            if (k == 30) check_output("t1_done_early", 64'(done), 64'd0);
            if (k == 31) check_output("t1_done_n32",   64'(done), 64'd1);
        end
        finish_snap(10);
        check_output("t1_drop", 64'(drop_cnt), 64'd0);

        // Test 2: delta with two changed registers
        $display("[TB] test 2: delta with two changes");
        regs[4]  = 32'hDEAD;
        regs[29] = 32'hBEEF;
        apply_stimulus(1'b1);
        finish_snap(20);

        // Test 3: empty delta, then first delta after reset behaves as full
        $display("[TB] test 3: empty delta and post-reset delta");
        apply_stimulus(1'b1);
        check_output("t3_no_valid", 64'(out_valid), 64'd0);
        check_output("t3_done_n1",  64'(done),      64'd1);
        finish_snap(5);
        do_reset();
        apply_stimulus(1'b1);
        finish_snap(50);

        // Test 4: random backpressure with gpr_flat changing mid-stream
        $display("[TB] test 4: backpressure");
        rand_en = 1'b1;
        apply_stimulus(1'b0);
        repeat (10) @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = ~regs[i];
        end
        finish_snap(400);
        rand_en   = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b1;

        // Test 5: dropped requests and counter saturation
        $display("[TB] test 5: drops");
        apply_stimulus(1'b0);
        snap_req = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        snap_req = 1'b0;
        finish_snap(50);
        check_output("t5_drop3", 64'(drop_cnt), 64'd3);
        out_ready = 1'b0;
        apply_stimulus(1'b0);
        snap_req = 1'b1;
        repeat (300) @(posedge clock);
        #1;
        snap_req = 1'b0;
        check_output("t5_stall_busy", 64'(busy),     64'd1);
        check_output("t5_drop_sat",   64'(drop_cnt), 64'd255);
        out_ready = 1'b1;
        finish_snap(50);

        // Test 6: flush after 10 beats, delta against pre-flush baseline, reset mid-stream
        $display("[TB] test 6: flush and reset mid-stream");
        regs[7] = 32'h7777;
        apply_stimulus(1'b0);
        repeat (10) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        exp_q.delete();
        check_output("t6_flush_valid", 64'(out_valid), 64'd0);
        check_output("t6_flush_busy",  64'(busy),      64'd0);
        repeat (2) @(posedge clock);
        #1;
        check_output("t6_flush_nodone", 64'(done_seen), 64'(done_exp));
        regs[2] = 32'h1234;
        apply_stimulus(1'b1);
        finish_snap(20);

        apply_stimulus(1'b0);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_base[i] = '0;
        end
        m_base_vld = 1'b0;
        @(posedge clock);
        #1;
        check_output("t6_rst_valid", 64'(out_valid), 64'd0);
        check_output("t6_rst_last",  64'(out_last),  64'd0);
        check_output("t6_rst_busy",  64'(busy),      64'd0);
        check_output("t6_rst_drop",  64'(drop_cnt),  64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_output("t6_rst_nodone", 64'(done_seen), 64'(done_exp));

        // flush and snap_req together in IDLE: request ignored and not counted
        flush    = 1'b1;
        snap_req = 1'b1;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        snap_req = 1'b0;
        check_output("idle_flush_busy", 64'(busy),     64'd0);
        check_output("idle_flush_drop", 64'(drop_cnt), 64'd0);
        @(posedge clock);
        #1;
        check_output("idle_flush_done", 64'(done_seen), 64'(done_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
